regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 XLEN, default 32, data width in bits.
REQ-002 NUM_REGS, default 32, number of architectural registers, including x0.
REQ-003 AW, default 5, register address width; NUM_REGS SHALL be less than or equal to 2**AW.
REQ-004 NRD, default 2, number of read ports, legal range 1..4.
REQ-005 clk  in  1  clock; every state update occurs on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rd_addr  in  NRD*AW  flattened read addresses; port k occupies bits [k*AW +: AW].
REQ-008 rd_data  out  NRD*XLEN  flattened read data, combinational.
REQ-009 rd_busy  out  NRD  per-port flag: the addressed register has a pending write.
REQ-010 wr_en0, wr_rd0, wr_data0  in  1/AW/XLEN  write port 0 (ALU writeback).
REQ-011 wr_en1, wr_rd1, wr_data1  in  1/AW/XLEN  write port 1 (load writeback).
REQ-012 issue_en, issue_rd  in  1/AW  marks issue_rd busy: an issued instruction will write it.
REQ-013 flush  in  1  clears all busy bits; register contents are untouched.
REQ-014 busy_count  out  AW+1  registered count of busy registers.

Function
REQ-015 Register file storage: NUM_REGS x XLEN; x0 SHALL read 0, SHALL never be written and SHALL never be busy.
REQ-016 Writes take effect on the clk edge when wr_enN=1 and wr_rdN!=0; an address >= NUM_REGS SHALL be ignored.
REQ-017 When both write ports target the same register in one cycle, port 1 SHALL win.
REQ-018 Read bypass: rd_data for a port SHALL equal the same-cycle write data when a write port targets the same nonzero address.
- Port 1 has priority over port 0 for the bypass.
- Otherwise rd_data SHALL equal the stored value.
- Combinational only; no added latency.
REQ-019 busy[r] SHALL be set on the edge when issue_en=1 and issue_rd=r, for r != 0.
REQ-020 busy[r] SHALL be cleared on the edge when any write port writes r.
REQ-021 When a set and a clear of the same register occur in the same cycle, the set SHALL win, and busy stays 1.
REQ-022 rd_busy[k] SHALL equal busy[addr_k] AND NOT (a write port is writing addr_k this cycle); this is clear-bypass.
REQ-023 A same-cycle issue SHALL NOT be visible on rd_busy until the next cycle.
REQ-024 flush=1 SHALL clear all busy bits on the edge; an issue in the same cycle SHALL be dropped; writes still proceed.
REQ-025 busy_count SHALL equal the popcount of the busy bits after the edge, updated every cycle, range 0..NUM_REGS-1.
REQ-026 All read-side outputs SHALL be combinational from the current state and inputs; busy_count SHALL be registered only.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, force all registers to 0, all busy bits to 0 and busy_count to 0.
REQ-028 While reset=1, writes, issue and flush SHALL be ignored.
REQ-029 Operation SHALL resume on the first clk edge after reset deasserts.
REQ-030 Asserting reset mid-operation SHALL discard all pending busy state.

Verification
REQ-031 Dual write collision:
- Stimulus: wr0 (x5, 0x11) and wr1 (x5, 0x22) in the same cycle, rd_addr0=x5.
- Response: rd_data0=0x22 the same cycle, and x5=0x22 after the edge.
REQ-032 x0 protection:
- Stimulus: wr0 (x0, 0xDEAD) and issue x0.
- Response: rd_data=0, rd_busy=0, busy_count unchanged.
REQ-033 Scoreboard:
- Stimulus: issue x3, then x7 on consecutive cycles; one cycle later, wr1 to x3.
- Response: busy_count goes 1, 2, 1; rd_busy for x3 is 0 in the writeback cycle.
REQ-034 Set/clear race:
- Stimulus: issue x9 and wr0 x9 in the same cycle, with x9 already busy.
- Response: x9 is still busy and busy_count is unchanged.
REQ-035 Flush:
- Stimulus: 4 registers busy; flush together with issue x12.
- Response: busy_count=0 next cycle and x12 not busy; register data preserved.
REQ-036 Asynchronous reset:
- Stimulus: assert reset mid-cycle with x4=0x55 and busy_count=3.
- Response: before the next edge, rd_data for x4 is 0 and busy_count is 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with dual writeback ports, read bypass and a per-register busy scoreboard.
// x0 is hardwired to zero and is never marked busy.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en0,
  input  logic [AW-1:0]       wr_rd0,
  input  logic [XLEN-1:0]     wr_data0,
  input  logic                wr_en1,
  input  logic [AW-1:0]       wr_rd1,
  input  logic [XLEN-1:0]     wr_data1,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  output logic [AW:0]         busy_count
);

  localparam logic [AW:0] NumRegs = (AW+1)'(NUM_REGS);

  // Nonzero and inside the implemented register range.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NumRegs);
  endfunction

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [AW:0]         busy_count_q, busy_count_d;
  logic                we0, we1, iss;
  logic [AW-1:0]       rd_a;
  logic                hit0, hit1;

  assign we0 = !reset && wr_en0 && addr_ok(wr_rd0);
  assign we1 = !reset && wr_en1 && addr_ok(wr_rd1);
  assign iss = !reset && issue_en && addr_ok(issue_rd) && !flush;

  // Port 1 is applied last so it wins a same-register collision.
  always_comb begin
    regs_d = regs_q;
    if (we0) regs_d[wr_rd0] = wr_data0;
    if (we1) regs_d[wr_rd1] = wr_data1;
    regs_d[0] = '0;
  end

  // Set is applied after the clears so an issue beats a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[wr_rd0] = 1'b0;
    if (we1) busy_d[wr_rd1] = 1'b0;
    if (iss) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_count_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_a    = '0;
    hit0    = 1'b0;
    hit1    = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_a = rd_addr[k*AW +: AW];
      hit0 = we0 && (rd_a == wr_rd0);
      hit1 = we1 && (rd_a == wr_rd1);
      if (addr_ok(rd_a)) begin
        if (hit1) begin
          rd_data[k*XLEN +: XLEN] = wr_data1;
        end else if (hit0) begin
          rd_data[k*XLEN +: XLEN] = wr_data0;
        end else begin
          rd_data[k*XLEN +: XLEN] = regs_q[rd_a];
        end
        rd_busy[k] = busy_q[rd_a] && !(hit0 || hit1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q       <= '{default: '0};
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus queues expected outputs, a negedge monitor compares.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en0, wr_en1, issue_en, flush;
  logic [AW-1:0]       wr_rd0, wr_rd1, issue_rd;
  logic [XLEN-1:0]     wr_data0, wr_data1;
  logic [AW:0]         busy_count;

  regfile_sb #(.XLEN(XLEN), .NUM_REGS(32), .AW(AW), .NRD(NRD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en0    (wr_en0),
    .wr_rd0    (wr_rd0),
    .wr_data0  (wr_data0),
    .wr_en1    (wr_en1),
    .wr_rd1    (wr_rd1),
    .wr_data1  (wr_data1),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .flush     (flush),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  // kind: 0 = rd_data[idx], 1 = rd_busy[idx], 2 = busy_count
  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic exp_rd(input int p, input logic [31:0] v);   push(0, p, v); endtask
  task automatic exp_busy(input int p, input logic [31:0] v); push(1, p, v); endtask
  task automatic exp_cnt(input logic [31:0] v);               push(2, 0, v); endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    string       nm;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        0:       begin act = rd_data[e.idx*XLEN +: XLEN];     nm = "rd_data"; end
        1:       begin act = 32'(rd_busy[e.idx]);             nm = "rd_busy"; end
        default: begin act = 32'(busy_count);                 nm = "busy_count"; end
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", nm, e.idx, $time, act, e.val);
      end
    end
  end

  task automatic idle();
    wr_en0 = 0; wr_rd0 = '0; wr_data0 = '0;
    wr_en1 = 0; wr_rd1 = '0; wr_data1 = '0;
    issue_en = 0; issue_rd = '0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr0(input int r, input logic [31:0] d);
    wr_en0 = 1; wr_rd0 = AW'(r); wr_data0 = d;
  endtask

  task automatic wr1(input int r, input logic [31:0] d);
    wr_en1 = 1; wr_rd1 = AW'(r); wr_data1 = d;
  endtask

  task automatic issue(input int r);
    issue_en = 1; issue_rd = AW'(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle();
    rd(2, 0);
    // Writes and issue during reset are ignored.
    step(); wr0(1, 32'hFF); issue(1); rd(2, 1);
    exp_rd(0, 0); exp_busy(1, 0); exp_cnt(0);
    step(); reset = 0; rd(1, 1);
    exp_rd(0, 0); exp_busy(0, 0); exp_cnt(0);

    // Dual-write collision: port 1 wins, bypassed the same cycle.
    step(); wr0(5, 32'h11); wr1(5, 32'h22); rd(5, 6);
    exp_rd(0, 32'h22); exp_rd(1, 0);
    step(); wr0(6, 32'h66); rd(5, 6);
    exp_rd(0, 32'h22); exp_rd(1, 32'h66);
    step(); rd(5, 6);
    exp_rd(1, 32'h66);

    // x0 protection.
    step(); wr0(0, 32'hDEAD); issue(0); rd(0, 5);
    exp_rd(0, 0); exp_busy(0, 0); exp_cnt(0);
    step(); rd(0, 5);
    exp_rd(0, 0); exp_busy(0, 0); exp_cnt(0);

    // Scoreboard: issue x3, x7, then writeback x3.
    step(); issue(3); rd(3, 7);
    exp_busy(0, 0); exp_cnt(0);
    step(); issue(7); rd(3, 7);
    exp_busy(0, 1); exp_busy(1, 0); exp_cnt(1);
    step(); wr1(3, 32'h33); rd(3, 7);
    exp_busy(0, 0); exp_rd(0, 32'h33); exp_busy(1, 1); exp_cnt(2);
    step(); rd(3, 7);
    exp_busy(0, 0); exp_rd(0, 32'h33); exp_busy(1, 1); exp_cnt(1);

    // Set/clear race on an already-busy x9.
    step(); issue(9); rd(9, 7);
    exp_cnt(1);
    step(); issue(9); wr0(9, 32'h99); rd(9, 7);
    exp_busy(0, 0); exp_rd(0, 32'h99); exp_cnt(2);
    step(); issue(10); rd(9, 7);
    exp_busy(0, 1); exp_cnt(2);

    // Flush with four busy (x7, x9, x10, x11) and a dropped issue of x12.
    step(); issue(11); rd(10, 9);
    exp_busy(0, 1); exp_cnt(3);
    step(); flush = 1; issue(12); wr0(13, 32'h13); rd(12, 11);
    exp_busy(0, 0); exp_busy(1, 1); exp_cnt(4);
    step(); rd(12, 7);
    exp_busy(0, 0); exp_busy(1, 0); exp_cnt(0);
    step(); rd(5, 13);
    exp_rd(0, 32'h22); exp_rd(1, 32'h13); exp_cnt(0);

    // Asynchronous reset mid-cycle with x4 = 0x55 and three busy.
    step(); wr0(4, 32'h55); issue(20); rd(4, 20);
    exp_cnt(0);
    step(); issue(21); rd(4, 20);
    exp_rd(0, 32'h55); exp_busy(1, 1); exp_cnt(1);
    step(); issue(22); rd(4, 21);
    exp_cnt(2);
    step(); rd(4, 20);
    exp_rd(0, 32'h55); exp_busy(1, 1); exp_cnt(3);
    step(); #1; reset = 1; rd(4, 20);
    exp_rd(0, 0); exp_busy(1, 0); exp_cnt(0);
    step(); reset = 0; rd(4, 5);
    exp_rd(0, 0); exp_rd(1, 0); exp_cnt(0);

    // Operation resumes after reset.
    step(); wr0(4, 32'h44); issue(8); rd(4, 8);
    exp_rd(0, 32'h44); exp_busy(1, 0);
    step(); rd(4, 8);
    exp_rd(0, 32'h44); exp_busy(1, 1); exp_cnt(1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
